// File: rtl/fifo_pkg.sv
// rtl/fifo_pkg.sv - shared defaults, clog2 and parameter-legality helpers for the sync FIFO
package fifo_pkg;

  localparam int DEFAULT_DATA_W = 8;
  localparam int DEFAULT_DEPTH  = 16;

  function automatic int clog2(input int n);
    int r;
    r = 0;
    while ((1 << r) < n) r = r + 1;
    return r;
  endfunction

  function automatic bit is_pow2(input int n);
    return (n >= 2) && ((n & (n - 1)) == 0);
  endfunction

  function automatic bit thresh_ok(input int depth, input int thresh);
    return (thresh >= 0) && (thresh <= depth);
  endfunction

endpackage

// File: rtl/fifo_mem.sv
// rtl/fifo_mem.sv - DEPTH x DATA_W register array, clocked write port, async read port
module fifo_mem
  import fifo_pkg::*;
#(
  parameter int DATA_W = DEFAULT_DATA_W,
  parameter int DEPTH  = DEFAULT_DEPTH,
  parameter int AW     = clog2(DEFAULT_DEPTH)
) (
  input  logic              clk,
  input  logic              we_i,
  input  logic [AW-1:0]     waddr_i,
  input  logic [DATA_W-1:0] wdata_i,
  input  logic [AW-1:0]     raddr_i,
  output logic [DATA_W-1:0] rdata_o
);

  // No reset: contents are only ever read after being written.
  logic [DATA_W-1:0] mem_q [DEPTH];

  always_ff @(posedge clk) begin
    if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/param_sync_fifo.sv
// rtl/param_sync_fifo.sv - parametrised single-clock FIFO with occupancy, thresholds and error pulses
// Define FIFO_FWFT_EN for first-word fall-through output; default is registered read data.
module param_sync_fifo
  import fifo_pkg::*;
#(
  parameter int DATA_W        = DEFAULT_DATA_W,
  parameter int DEPTH         = DEFAULT_DEPTH,
  parameter int AFULL_THRESH  = 14,
  parameter int AEMPTY_THRESH = 2
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  wr_en_i,
  input  logic [DATA_W-1:0]     data_i,
  input  logic                  rd_en_i,
  output logic [DATA_W-1:0]     data_o,
  output logic                  full_o,
  output logic                  empty_o,
  output logic                  almost_full_o,
  output logic                  almost_empty_o,
  output logic [clog2(DEPTH):0] count_o,
  output logic                  overflow_o,
  output logic                  underflow_o
);

  localparam int AW = clog2(DEPTH);
  localparam int CW = AW + 1;

  if (!is_pow2(DEPTH)) begin : g_bad_depth
    $error("param_sync_fifo: DEPTH must be a power of two >= 2");
  end
  if (!thresh_ok(DEPTH, AFULL_THRESH) || !thresh_ok(DEPTH, AEMPTY_THRESH)) begin : g_bad_thresh
    $error("param_sync_fifo: thresholds must lie within 0..DEPTH");
  end

  logic [AW-1:0]     wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]     rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]     count_q, count_d;
  logic              overflow_q, underflow_q;
  logic              wr_acc, rd_acc;
  logic [DATA_W-1:0] mem_rdata;

  assign full_o         = (count_q == CW'(DEPTH));
  assign empty_o        = (count_q == '0);
  assign almost_full_o  = (count_q >= CW'(AFULL_THRESH));
  assign almost_empty_o = (count_q <= CW'(AEMPTY_THRESH));
  assign count_o        = count_q;
  assign overflow_o     = overflow_q;
  assign underflow_o    = underflow_q;

  // Acceptance uses pre-edge flags, so a same-cycle pop never makes room for a push.
  assign wr_acc = wr_en_i & ~full_o;
  assign rd_acc = rd_en_i & ~empty_o;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (wr_acc) wr_ptr_d = wr_ptr_q + AW'(1);
    if (rd_acc) rd_ptr_d = rd_ptr_q + AW'(1);
    case ({wr_acc, rd_acc})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  fifo_mem #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH),
    .AW     (AW)
  ) u_mem (
    .clk     (clk),
    .we_i    (wr_acc),
    .waddr_i (wr_ptr_q),
    .wdata_i (data_i),
    .raddr_i (rd_ptr_q),
    .rdata_o (mem_rdata)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      overflow_q  <= wr_en_i & full_o;
      underflow_q <= rd_en_i & empty_o;
    end
  end

`ifdef FIFO_FWFT_EN
  assign data_o = mem_rdata;
`else
  logic [DATA_W-1:0] data_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      data_q <= '0;
    end else if (rd_acc) begin
      data_q <= mem_rdata;
    end
  end

  assign data_o = data_q;
`endif

endmodule

// File: tb/tb_param_sync_fifo.sv
// tb/tb_param_sync_fifo.sv - queue-model checker plus directed vectors for param_sync_fifo
module tb_param_sync_fifo;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       wr_en = 1'b0;
  logic       rd_en = 1'b0;
  logic [7:0] din = 8'h00;
  logic [7:0] data_o;
  logic       full_o, empty_o, afull_o, aempty_o, ovf_o, udf_o;
  logic [4:0] count_o;

  int n_checks = 0;
  int n_fail   = 0;

  param_sync_fifo #(
    .DATA_W        (8),
    .DEPTH         (16),
    .AFULL_THRESH  (14),
    .AEMPTY_THRESH (2)
  ) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .wr_en_i        (wr_en),
    .data_i         (din),
    .rd_en_i        (rd_en),
    .data_o         (data_o),
    .full_o         (full_o),
    .empty_o        (empty_o),
    .almost_full_o  (afull_o),
    .almost_empty_o (aempty_o),
    .count_o        (count_o),
    .overflow_o     (ovf_o),
    .underflow_o    (udf_o)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks = n_checks + 1;
    if (act !== exp) begin
      n_fail = n_fail + 1;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: a plain queue of accepted words plus the last popped word.
  logic [7:0] mq[$];
  logic [7:0] m_data = 8'h00;
  bit         m_ovf = 1'b0;
  bit         m_udf = 1'b0;
  bit         m_valid = 1'b0;

  always @(posedge clk) begin
    if (!rst_n) begin
      mq.delete();
      m_data  = 8'h00;
      m_ovf   = 1'b0;
      m_udf   = 1'b0;
      m_valid = 1'b1;
    end else begin
      m_ovf = wr_en && (mq.size() == 16);
      m_udf = rd_en && (mq.size() == 0);
      if (rd_en && mq.size() != 0) m_data = mq.pop_front();
      if (wr_en && !m_ovf) mq.push_back(din);
    end
  end

  always @(negedge clk) begin
    if (m_valid) begin
      chk("count",     32'(count_o),  32'(mq.size()));
      chk("empty",     32'(empty_o),  32'(mq.size() == 0));
      chk("full",      32'(full_o),   32'(mq.size() == 16));
      chk("afull",     32'(afull_o),  32'(mq.size() >= 14));
      chk("aempty",    32'(aempty_o), 32'(mq.size() <= 2));
      chk("overflow",  32'(ovf_o),    32'(m_ovf));
      chk("underflow", 32'(udf_o),    32'(m_udf));
`ifdef FIFO_FWFT_EN
      if (mq.size() != 0) chk("data_fwft", 32'(data_o), 32'(mq[0]));
`else
      chk("data", 32'(data_o), 32'(m_data));
`endif
    end
  end

  task automatic step(input bit rn, input bit w, input logic [7:0] d, input bit r);
    rst_n = rn;
    wr_en = w;
    din   = d;
    rd_en = r;
    @(posedge clk);
    #1;
  endtask

  initial begin
    step(0, 0, 8'h00, 0);
    step(0, 0, 8'h00, 0);
    step(1, 0, 8'h00, 0);
    step(1, 0, 8'h00, 0);
    chk("lit_reset_count", 32'(count_o), 32'd0);
    chk("lit_reset_empty", 32'(empty_o), 32'd1);
    chk("lit_reset_data",  32'(data_o),  32'h00);

    for (int i = 0; i < 16; i++) begin
      step(1, 1, 8'(i + 1), 0);
      if (i == 12) chk("lit_afull_13", 32'(afull_o), 32'd0);
      if (i == 13) chk("lit_afull_14", 32'(afull_o), 32'd1);
    end
    chk("lit_full_count", 32'(count_o), 32'd16);
    chk("lit_full_flag",  32'(full_o),  32'd1);
    step(1, 1, 8'hAA, 0);
    chk("lit_overflow", 32'(ovf_o),   32'd1);
    chk("lit_ovf_cnt",  32'(count_o), 32'd16);
    step(1, 0, 8'h00, 0);
    chk("lit_overflow_clear", 32'(ovf_o), 32'd0);

    for (int i = 0; i < 16; i++) begin
`ifdef FIFO_FWFT_EN
      chk("lit_pop_data", 32'(data_o), 32'(i + 1));
      step(1, 0, 8'h00, 1);
`else
      step(1, 0, 8'h00, 1);
      chk("lit_pop_data", 32'(data_o), 32'(i + 1));
`endif
    end
    step(1, 0, 8'h00, 1);
    chk("lit_underflow", 32'(udf_o), 32'd1);
`ifndef FIFO_FWFT_EN
    chk("lit_udf_hold", 32'(data_o), 32'h10);
`endif
    step(1, 0, 8'h00, 0);

    for (int i = 0; i < 5; i++) step(1, 1, 8'(8'h20 + i), 0);
    for (int i = 0; i < 40; i++) step(1, 1, 8'(8'h30 + i), 1);
    chk("lit_steady_count", 32'(count_o), 32'd5);

    for (int i = 0; i < 11; i++) step(1, 1, 8'(8'h40 + i), 0);
    step(1, 1, 8'hBB, 1);
    chk("lit_full_pp_ovf", 32'(ovf_o),   32'd1);
    chk("lit_full_pp_cnt", 32'(count_o), 32'd15);
    for (int i = 0; i < 15; i++) step(1, 0, 8'h00, 1);
    step(1, 1, 8'hCC, 1);
    chk("lit_empty_pp_udf", 32'(udf_o),   32'd1);
    chk("lit_empty_pp_cnt", 32'(count_o), 32'd1);

    for (int i = 0; i < 8; i++) step(1, 1, 8'(8'h60 + i), 0);
    chk("lit_pre_reset_cnt", 32'(count_o), 32'd9);
    step(0, 0, 8'h00, 0);
    chk("lit_midreset_cnt",   32'(count_o), 32'd0);
    chk("lit_midreset_empty", 32'(empty_o), 32'd1);
    step(1, 1, 8'h55, 0);
`ifdef FIFO_FWFT_EN
    chk("lit_fwft_55", 32'(data_o), 32'h55);
`endif
    step(1, 0, 8'h00, 1);
`ifndef FIFO_FWFT_EN
    chk("lit_std_55", 32'(data_o), 32'h55);
`endif
    step(1, 0, 8'h00, 0);
    step(1, 0, 8'h00, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
